// File: rtl/midi_msg_parser_pkg.sv
// Shared definitions for the MIDI channel-message parser.
// - ev_type_e   : decoded event type presented on ev_type
// - Stat*       : channel-voice status nibbles
// - SysexStart / SysexEnd / RtMin : system byte boundaries
// - state_e     : parser FSM states
package midi_msg_parser_pkg;

  typedef enum logic [2:0] {
    EvNoteOff   = 3'd0,
    EvNoteOn    = 3'd1,
    EvPolyAt    = 3'd2,
    EvCc        = 3'd3,
    EvProgram   = 3'd4,
    EvChanAt    = 3'd5,
    EvPitchBend = 3'd6
  } ev_type_e;

  localparam logic [3:0] StatNoteOff   = 4'h8;
  localparam logic [3:0] StatNoteOn    = 4'h9;
  localparam logic [3:0] StatPolyAt    = 4'hA;
  localparam logic [3:0] StatCc        = 4'hB;
  localparam logic [3:0] StatProgram   = 4'hC;
  localparam logic [3:0] StatChanAt    = 4'hD;
  localparam logic [3:0] StatPitchBend = 4'hE;

  localparam logic [7:0] SysexStart = 8'hF0;
  localparam logic [7:0] SysexEnd   = 8'hF7;
  localparam logic [7:0] RtMin      = 8'hF8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitD1 = 2'd1,
    StWaitD2 = 2'd2,
    StSysex  = 2'd3
  } state_e;

  // Real-time bytes may appear anywhere and never disturb parsing.
  function automatic logic is_realtime(input logic [7:0] b);
    return (b >= RtMin);
  endfunction

endpackage

// File: rtl/midi_msg_parser_msg_len.sv
// Combinational decode of a channel status nibble.
// Ports:
//   status_nibble : high nibble of the running status byte (0x8..0xE)
//   two_bytes     : 1 when the message carries two data bytes, 0 for one
//   ev_type       : event type encoding for this status
module midi_msg_parser_msg_len
  import midi_msg_parser_pkg::*;
(
  input  logic [3:0] status_nibble,
  output logic       two_bytes,
  output ev_type_e   ev_type
);

  always_comb begin
    two_bytes = 1'b1;
    ev_type   = EvNoteOff;
    case (status_nibble)
      StatNoteOff:   ev_type = EvNoteOff;
      StatNoteOn:    ev_type = EvNoteOn;
      StatPolyAt:    ev_type = EvPolyAt;
      StatCc:        ev_type = EvCc;
      StatProgram: begin
        ev_type   = EvProgram;
        two_bytes = 1'b0;
      end
      StatChanAt: begin
        ev_type   = EvChanAt;
        two_bytes = 1'b0;
      end
      StatPitchBend: ev_type = EvPitchBend;
      default: ;
    endcase
  end

endmodule

// File: rtl/midi_msg_parser.sv
// Byte-level MIDI channel-message parser. Turns received UART bytes into one
// decoded channel-voice event per complete message, with running status,
// real-time interleave, SysEx skipping and note-on velocity 0 -> note-off.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   rx_byte    : received byte, qualified by rx_valid (one-cycle strobe)
//   ev_valid   : one-cycle strobe, one clock after the final data byte
//   ev_type    : 0 NOTE_OFF .. 6 PITCH_BEND
//   ev_channel : status low nibble
//   ev_data1   : first data byte
//   ev_data2   : second data byte, 0 for one-byte messages
// Fields hold their value between emissions.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       ev_valid,
  output logic [2:0] ev_type,
  output logic [3:0] ev_channel,
  output logic [6:0] ev_data1,
  output logic [6:0] ev_data2
);

  state_e     state_q, state_d;
  logic [7:0] rs_q, rs_d;       // running status byte, 0 when cleared
  logic [6:0] data1_q, data1_d;

  logic       ev_valid_q, ev_valid_d;
  ev_type_e   ev_type_q, ev_type_d;
  logic [3:0] ev_channel_q, ev_channel_d;
  logic [6:0] ev_data1_q, ev_data1_d;
  logic [6:0] ev_data2_q, ev_data2_d;

  logic       two_bytes;
  ev_type_e   rs_type;
  logic       msg_done;
  logic [6:0] msg_d1, msg_d2;
  ev_type_e   msg_type;
  logic       chan_ok;

  midi_msg_parser_msg_len u_msg_len (
    .status_nibble (rs_q[7:4]),
    .two_bytes     (two_bytes),
    .ev_type       (rs_type)
  );

  // Filtered messages are still parsed; only the strobe and field update are gated.
  assign chan_ok = OMNI || (rs_q[3:0] == CHANNEL);

  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    data1_d      = data1_q;
    msg_done     = 1'b0;
    msg_d1       = '0;
    msg_d2       = '0;
    msg_type     = rs_type;
    ev_valid_d   = 1'b0;
    ev_type_d    = ev_type_q;
    ev_channel_d = ev_channel_q;
    ev_data1_d   = ev_data1_q;
    ev_data2_d   = ev_data2_q;

    if (rx_valid && !is_realtime(rx_byte)) begin
      if (rx_byte[7]) begin
        if (rx_byte < SysexStart) begin
          // Channel status: new running status, any partial message dropped.
          rs_d    = rx_byte;
          state_d = StWaitD1;
        end else begin
          // System common (incl. SysEx end) cancels running status.
          rs_d    = '0;
          state_d = (rx_byte == SysexStart) ? StSysex : StIdle;
        end
      end else begin
        unique case (state_q)
          StWaitD1: begin
            if (two_bytes) begin
              data1_d = rx_byte[6:0];
              state_d = StWaitD2;
            end else begin
              msg_done = 1'b1;
              msg_d1   = rx_byte[6:0];
            end
          end
          StWaitD2: begin
            msg_done = 1'b1;
            msg_d1   = data1_q;
            msg_d2   = rx_byte[6:0];
            state_d  = StWaitD1;
          end
          default: ;  // Idle / SysEx: data bytes discarded
        endcase
      end
    end

    if (msg_done) begin
      if (rs_type == EvNoteOn && msg_d2 == 7'd0) begin
        msg_type = EvNoteOff;
      end
      if (chan_ok) begin
        ev_valid_d   = 1'b1;
        ev_type_d    = msg_type;
        ev_channel_d = rs_q[3:0];
        ev_data1_d   = msg_d1;
        ev_data2_d   = msg_d2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rs_q         <= '0;
      data1_q      <= '0;
      ev_valid_q   <= 1'b0;
      ev_type_q    <= EvNoteOff;
      ev_channel_q <= '0;
      ev_data1_q   <= '0;
      ev_data2_q   <= '0;
    end else begin
      state_q      <= state_d;
      rs_q         <= rs_d;
      data1_q      <= data1_d;
      ev_valid_q   <= ev_valid_d;
      ev_type_q    <= ev_type_d;
      ev_channel_q <= ev_channel_d;
      ev_data1_q   <= ev_data1_d;
      ev_data2_q   <= ev_data2_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_type    = ev_type_q;
  assign ev_channel = ev_channel_q;
  assign ev_data1   = ev_data1_q;
  assign ev_data2   = ev_data2_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;

  logic       a_valid, b_valid;
  logic [2:0] a_type, b_type;
  logic [3:0] a_chan, b_chan;
  logic [6:0] a_d1, a_d2, b_d1, b_d2;

  int checks = 0;
  int errors = 0;

  always #31 clk = ~clk;

  midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) u_omni (
    .clk (clk), .rst (rst), .rx_byte (rx_byte), .rx_valid (rx_valid),
    .ev_valid (a_valid), .ev_type (a_type), .ev_channel (a_chan),
    .ev_data1 (a_d1), .ev_data2 (a_d2)
  );

  midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd4)) u_ch4 (
    .clk (clk), .rst (rst), .rx_byte (rx_byte), .rx_valid (rx_valid),
    .ev_valid (b_valid), .ev_type (b_type), .ev_channel (b_chan),
    .ev_data1 (b_d1), .ev_data2 (b_d2)
  );

  // Reference model: message-assembly view of the MIDI stream.
  logic [7:0] m_rs;          // running status, 0 = none
  logic [7:0] m_msg[$];      // data bytes collected for the current message
  logic       ea_valid, eb_valid;
  logic [2:0] ea_type, eb_type;
  logic [3:0] ea_chan, eb_chan;
  logic [6:0] ea_d1, ea_d2, eb_d1, eb_d2;

  function automatic int msg_len(input logic [7:0] status);
    return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_rs = 8'h00;
    m_msg.delete();
    ea_valid = 0; ea_type = 0; ea_chan = 0; ea_d1 = 0; ea_d2 = 0;
    eb_valid = 0; eb_type = 0; eb_chan = 0; eb_d1 = 0; eb_d2 = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int t;
    logic [6:0] d1, d2;
    ea_valid = 0;
    eb_valid = 0;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_rs = (b < 8'hF0) ? b : 8'h00;
      m_msg.delete();
      return;
    end
    if (m_rs == 8'h00) return;
    m_msg.push_back(b);
    if (m_msg.size() == msg_len(m_rs)) begin
      t  = int'(m_rs[7:4]) - 8;
      d1 = m_msg[0][6:0];
      d2 = (m_msg.size() == 2) ? m_msg[1][6:0] : 7'd0;
      if (t == 1 && d2 == 0) t = 0;
      ea_valid = 1; ea_type = 3'(t); ea_chan = m_rs[3:0]; ea_d1 = d1; ea_d2 = d2;
      if (m_rs[3:0] == 4'd4) begin
        eb_valid = 1; eb_type = 3'(t); eb_chan = m_rs[3:0]; eb_d1 = d1; eb_d2 = d2;
      end
      m_msg.delete();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a_valid"}, 32'(a_valid), 32'(ea_valid));
    check({tag, ".a_type"},  32'(a_type),  32'(ea_type));
    check({tag, ".a_chan"},  32'(a_chan),  32'(ea_chan));
    check({tag, ".a_d1"},    32'(a_d1),    32'(ea_d1));
    check({tag, ".a_d2"},    32'(a_d2),    32'(ea_d2));
    check({tag, ".b_valid"}, 32'(b_valid), 32'(eb_valid));
    check({tag, ".b_type"},  32'(b_type),  32'(eb_type));
    check({tag, ".b_chan"},  32'(b_chan),  32'(eb_chan));
    check({tag, ".b_d1"},    32'(b_d1),    32'(eb_d1));
    check({tag, ".b_d2"},    32'(b_d2),    32'(eb_d2));
  endtask

  // One clock of stimulus; outputs checked #1 after the capturing edge.
  task automatic step(input logic [7:0] b, input bit valid, input string tag);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = valid;
    if (valid) model_byte(b);
    else begin
      ea_valid = 0;
      eb_valid = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_seq(input logic [7:0] seq[$], input string tag);
    foreach (seq[i]) step(seq[i], 1'b1, tag);
    step(8'h00, 1'b0, {tag, ".idle"});
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 10) return 8'h00;
    if (r < 55) return 8'($urandom_range(0, 127));
    if (r < 80) return 8'($urandom_range(8'h80, 8'hEF));
    if (r < 88) return 8'($urandom_range(8'hF8, 8'hFF));
    if (r < 93) return 8'hF0;
    if (r < 96) return 8'hF7;
    return 8'($urandom_range(8'hF1, 8'hF6));
  endfunction

  initial begin
    logic [7:0] seq[$];
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    seq = '{8'h90, 8'h3C, 8'h64};
    send_seq(seq, "note_on");
    seq = '{8'h91, 8'h40, 8'h7F, 8'h43, 8'h00};
    send_seq(seq, "running");
    seq = '{8'hB2, 8'hF8, 8'h07, 8'hFE, 8'h50};
    send_seq(seq, "realtime");
    seq = '{8'hC5, 8'h0A};
    send_seq(seq, "program");
    seq = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h22};
    send_seq(seq, "sysex");
    seq = '{8'h80, 8'h30, 8'hE3, 8'h00, 8'h40};
    send_seq(seq, "abandon");
    seq = '{8'h94, 8'h3C, 8'h64, 8'h95, 8'h3C, 8'h64};
    send_seq(seq, "filter");

    // Reset mid-message: partial message lost, outputs return to 0.
    step(8'h90, 1'b1, "rst_mid.s");
    step(8'h3C, 1'b1, "rst_mid.d1");
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_mid.async");
    @(negedge clk);
    rst = 1'b0;
    step(8'h50, 1'b1, "rst_mid.after");
    step(8'h00, 1'b0, "rst_mid.idle");

    for (int i = 0; i < 1500; i++) begin
      step(rand_byte(), ($urandom_range(0, 99) < 85), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
